score_pulse_gen: RTL

SCORE_PULSE_GEN -- requirements
Module: score_pulse_gen

---
 rtl/score_pulse_gen_if.sv | 40 ++++
 rtl/score_pulse_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/score_pulse_gen_if.sv
// Bundles the score_pulse_gen strobe inputs and score outputs.
// With SCORE_PULSE_FREEZE_EN defined, the bundle also carries the freeze input.
interface score_pulse_gen_if #(
    parameter int unsigned PEND_W = 8
);
    logic [3:0]        wall_hit;
    logic              enemy_hit;
    logic              clear;
`ifdef SCORE_PULSE_FREEZE_EN
    logic              freeze;
`endif
    logic              increment_score;
    logic [PEND_W-1:0] pending;
    logic              busy;
    logic              overflow;

`ifdef SCORE_PULSE_FREEZE_EN
    // Game-logic side: issues strobes and observes the score pulses.
    modport master (
        output wall_hit, enemy_hit, clear, freeze,
        input  increment_score, pending, busy, overflow
    );
    // Pulse generator side.
    modport slave (
        input  wall_hit, enemy_hit, clear, freeze,
        output increment_score, pending, busy, overflow
    );
`else
    // Game-logic side: issues strobes and observes the score pulses.
    modport master (
        output wall_hit, enemy_hit, clear,
        input  increment_score, pending, busy, overflow
    );
    // Pulse generator side.
    modport slave (
        input  wall_hit, enemy_hit, clear,
        output increment_score, pending, busy, overflow
    );
`endif
endinterface

// File: rtl/score_pulse_gen.sv
// score_pulse_gen: converts wall/enemy hit strobes into a stream of
// single-point increment_score pulses, spaced by PULSE_GAP idle cycles.
// Points waiting to be pulsed out accumulate in a saturating counter.
// Optional feature macro: SCORE_PULSE_FREEZE_EN adds a freeze input that
// holds off new pulses while credit keeps accumulating.
module score_pulse_gen #(
    parameter int unsigned ENEMY_POINTS = 5,
    parameter int unsigned PULSE_GAP    = 1,
    parameter int unsigned PEND_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    score_pulse_gen_if.slave   bus
);
    // Headroom so pending + max credit never wraps, even for narrow PEND_W.
    localparam int unsigned   SUM_W    = PEND_W + 5;
    localparam int unsigned   CRED_W   = 5;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [3:0]    GAP_LAST = (PULSE_GAP == 0) ? 4'd0 : 4'(PULSE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        gap_q;
    logic [PEND_W-1:0] pending_q;
    logic              inc_q;
    logic              busy_q;
    logic              ovf_q;

    logic              frz_c;
    logic [CRED_W-1:0] credit_c;
    logic [SUM_W-1:0]  sum_c;
    logic              sat_c;
    logic [PEND_W-1:0] pend_nxt_c;
    logic              pend_nz_c;
    logic              pend_nxt_nz_c;

`ifdef SCORE_PULSE_FREEZE_EN
    assign frz_c = bus.freeze;
`else
    assign frz_c = 1'b0;
`endif

    // Points credited this cycle and the saturated next pending count.
    always_comb begin
        credit_c   = CRED_W'($countones(bus.wall_hit))
                   + (bus.enemy_hit ? CRED_W'(ENEMY_POINTS) : CRED_W'(0));
        sum_c      = SUM_W'(pending_q) + SUM_W'(credit_c) - SUM_W'(state_q == PULSE);
        sat_c      = (sum_c > SUM_W'(PEND_MAX));
        pend_nxt_c = sat_c ? PEND_MAX : sum_c[PEND_W-1:0];
        pend_nz_c     = (pending_q != '0);
        pend_nxt_nz_c = (pend_nxt_c != '0);
    end

    // Pending-points counter and sticky saturation flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else if (bus.clear) begin
            pending_q <= '0;
        end else begin
            pending_q <= pend_nxt_c;
            if (sat_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Pulse sequencer: IDLE -> PULSE -> (GAP) -> PULSE/IDLE, with registered pulse and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gap_q   <= 4'd0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (bus.clear) begin
            state_q <= IDLE;
            gap_q   <= 4'd0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_nz_c && !frz_c) begin
                        state_q <= PULSE;
                        inc_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        inc_q   <= 1'b0;
                        busy_q  <= pend_nxt_nz_c;
                    end
                end
                PULSE: begin
                    if (PULSE_GAP != 0) begin
                        state_q <= GAP;
                        gap_q   <= GAP_LAST;
                        inc_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (pend_nxt_nz_c && !frz_c) begin
                        state_q <= PULSE;
                        inc_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        inc_q   <= 1'b0;
                        busy_q  <= pend_nxt_nz_c;
                    end
                end
                GAP: begin
                    inc_q <= 1'b0;
                    if (gap_q != 4'd0) begin
                        gap_q  <= gap_q - 4'd1;
                        busy_q <= 1'b1;
                    end else if (pend_nz_c && !frz_c) begin
                        state_q <= PULSE;
                        inc_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (pend_nz_c) begin
                        // Frozen with points waiting: hold at the end of the gap.
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= pend_nxt_nz_c;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gap_q   <= 4'd0;
                    inc_q   <= 1'b0;
                    busy_q  <= pend_nxt_nz_c;
                end
            endcase
        end
    end

    assign bus.increment_score = inc_q;
    assign bus.pending         = pending_q;
    assign bus.busy            = busy_q;
    assign bus.overflow        = ovf_q;

endmodule
